// File: rtl/loss_of_beam_multi_if.sv
// rtl/loss_of_beam_multi_if.sv - GPIO configuration strobes and turn-by-turn sample inputs
interface loss_of_beam_multi_if #(
  parameter int NCHAN      = 4,
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]       gpioData;
  logic                        thresholdStrobe;
  logic                        countStrobe;
  logic                        enableStrobe;
  logic                        clearStrobe;
  logic                        turnByTurnToggle;
  logic [NCHAN*DATA_WIDTH-1:0] buttonSum;

  modport master (
    output gpioData, thresholdStrobe, countStrobe, enableStrobe, clearStrobe,
    output turnByTurnToggle, buttonSum
  );

  modport slave (
    input gpioData, thresholdStrobe, countStrobe, enableStrobe, clearStrobe,
    input turnByTurnToggle, buttonSum
  );
endinterface

// File: rtl/loss_of_beam_multi.sv
// rtl/loss_of_beam_multi.sv - multi-channel loss-of-beam trigger with per-channel limit history
module loss_of_beam_multi #(
  parameter int NCHAN        = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int HISTORY_SIZE = 64,
  parameter int DATA_SHIFT   = 3,
  parameter int L2_ALPHA     = 3,
  parameter int COUNT_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  loss_of_beam_multi_if.slave    bus,
  output logic [DATA_WIDTH-1:0]  threshold,
  output logic [COUNT_WIDTH-1:0] tripCount,
  output logic [NCHAN-1:0]       channelEnable,
  output logic [NCHAN-1:0]       tripFlags,
  output logic                   lossOfBeamTrigger,
  output logic                   overrun,
  output logic                   busy
);
  localparam int CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int AW    = $clog2(HISTORY_SIZE);
  localparam int IW    = CW + AW;
  localparam int DEPTH = 1 << IW;
  localparam int NSLOT = 1 << CW;

  typedef enum logic [1:0] {IDLE, SMOOTH, LIMIT, WRITE} state_t;

  state_t                 state;
  logic [CW-1:0]          chan;
  logic [AW-1:0]          addr;
  logic                   turnByTurnMatch;
  logic [DATA_WIDTH-1:0]  snap  [NSLOT];
  logic [DATA_WIDTH-1:0]  y_reg [NSLOT];
  logic [COUNT_WIDTH-1:0] run   [NSLOT];
  logic [DATA_WIDTH-1:0]  hist  [DEPTH];
  logic [DEPTH-1:0]       hist_valid;
  logic [DATA_WIDTH-1:0]  lim_q;
  logic [DATA_WIDTH-1:0]  d_q;

  logic [IW-1:0]            idx;
  logic [DATA_WIDTH-1:0]    y_cur;
  logic [DATA_WIDTH-1:0]    u_cur;
  logic signed [DATA_WIDTH:0] diff;
  logic signed [DATA_WIDTH:0] step;
  logic [DATA_WIDTH-1:0]    y_next;
  logic                     en_cur;
  logic                     below;
  logic [COUNT_WIDTH:0]     run_inc;
  logic [COUNT_WIDTH-1:0]   cnt_eff;
  logic                     trip_now;
  logic [NCHAN-1:0]         set_mask;
  logic [DATA_WIDTH-1:0]    kept;
  logic [DATA_WIDTH:0]      dd;
  logic [DATA_WIDTH-1:0]    d_next;

  always_comb begin
    idx    = {chan, addr};
    y_cur  = y_reg[chan];
    u_cur  = snap[chan];
    diff   = $signed({1'b0, u_cur}) - $signed({1'b0, y_cur});
    step   = diff >>> L2_ALPHA;
    y_next = DATA_WIDTH'($signed({1'b0, y_cur}) + step);

    en_cur = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (chan == CW'(i)) en_cur = channelEnable[i];
    end

    // In LIMIT y_cur already holds the freshly smoothed value
    below    = (y_cur < lim_q) && en_cur;
    run_inc  = {1'b0, run[chan]} + 1'b1;
    cnt_eff  = (tripCount == '0) ? COUNT_WIDTH'(1) : tripCount;
    trip_now = (state == LIMIT) && below && (run_inc >= {1'b0, cnt_eff});

    set_mask = '0;
    for (int i = 0; i < NCHAN; i++) begin
      set_mask[i] = trip_now && (chan == CW'(i));
    end

    kept   = y_cur - (y_cur >> DATA_SHIFT);
    dd     = {1'b0, kept} - {1'b0, threshold};
    d_next = dd[DATA_WIDTH] ? '0 : dd[DATA_WIDTH-1:0];
  end

  // History storage has no reset; hist_valid masks stale contents
  always_ff @(posedge clk) begin
    if (!reset && state == WRITE) hist[idx] <= d_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      chan              <= '0;
      addr              <= '0;
      turnByTurnMatch   <= bus.turnByTurnToggle;
      busy              <= 1'b0;
      threshold         <= '0;
      tripCount         <= COUNT_WIDTH'(1);
      channelEnable     <= '1;
      tripFlags         <= '0;
      lossOfBeamTrigger <= 1'b0;
      overrun           <= 1'b0;
      hist_valid        <= '0;
      lim_q             <= '0;
      d_q               <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        snap[i]  <= '0;
        y_reg[i] <= '0;
        run[i]   <= '0;
      end
    end else begin
      if (bus.thresholdStrobe) threshold     <= bus.gpioData;
      if (bus.countStrobe)     tripCount     <= bus.gpioData[COUNT_WIDTH-1:0];
      if (bus.enableStrobe)    channelEnable <= bus.gpioData[NCHAN-1:0];

      // A trip arriving with clear wins over the clear
      tripFlags         <= (bus.clearStrobe ? '0 : tripFlags) | set_mask;
      overrun           <= (bus.clearStrobe ? 1'b0 : overrun) |
                           (busy && (bus.turnByTurnToggle != turnByTurnMatch));
      lossOfBeamTrigger <= |tripFlags;

      case (state)
        IDLE: begin
          if (bus.turnByTurnToggle != turnByTurnMatch) begin
            turnByTurnMatch <= ~turnByTurnMatch;
            for (int i = 0; i < NCHAN; i++) begin
              snap[i] <= bus.buttonSum[i*DATA_WIDTH +: DATA_WIDTH];
            end
            chan  <= '0;
            busy  <= 1'b1;
            state <= SMOOTH;
          end
        end
        SMOOTH: begin
          y_reg[chan] <= y_next;
          lim_q       <= hist_valid[idx] ? hist[idx] : '0;
          state       <= LIMIT;
        end
        LIMIT: begin
          if (below) run[chan] <= (run[chan] == '1) ? run[chan] : run_inc[COUNT_WIDTH-1:0];
          else       run[chan] <= '0;
          d_q   <= d_next;
          state <= WRITE;
        end
        WRITE: begin
          hist_valid[idx] <= 1'b1;
          if (chan == CW'(NCHAN - 1)) begin
            addr  <= addr + 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            chan  <= chan + 1'b1;
            state <= SMOOTH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_loss_of_beam_multi.sv
// tb/tb_loss_of_beam_multi.sv - directed bench with a turn-level reference model
module tb_loss_of_beam_multi;
  localparam int NCH = 2, DW = 32, HS = 4, SH = 3, CWD = 4, AL_A = 0, AL_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  loss_of_beam_multi_if #(.NCHAN(NCH), .DATA_WIDTH(DW)) bus_a ();
  loss_of_beam_multi_if #(.NCHAN(NCH), .DATA_WIDTH(DW)) bus_b ();

  logic [DW-1:0]  thr_a, thr_b;
  logic [CWD-1:0] cnt_a, cnt_b;
  logic [NCH-1:0] en_a, en_b, flags_a, flags_b;
  logic           trig_a, trig_b, ovr_a, ovr_b, busy_a, busy_b;

  loss_of_beam_multi #(.NCHAN(NCH), .DATA_WIDTH(DW), .HISTORY_SIZE(HS), .DATA_SHIFT(SH),
                       .L2_ALPHA(AL_A), .COUNT_WIDTH(CWD)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a), .threshold(thr_a), .tripCount(cnt_a),
    .channelEnable(en_a), .tripFlags(flags_a), .lossOfBeamTrigger(trig_a),
    .overrun(ovr_a), .busy(busy_a));

  loss_of_beam_multi #(.NCHAN(NCH), .DATA_WIDTH(DW), .HISTORY_SIZE(HS), .DATA_SHIFT(SH),
                       .L2_ALPHA(AL_B), .COUNT_WIDTH(CWD)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b), .threshold(thr_b), .tripCount(cnt_b),
    .channelEnable(en_b), .tripFlags(flags_b), .lossOfBeamTrigger(trig_b),
    .overrun(ovr_b), .busy(busy_b));

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Reference model: one call per turn, arrays indexed by channel and history slot
  logic [DW-1:0]  m_thr;
  logic [CWD-1:0] m_cnt;
  logic [NCH-1:0] m_en, m_flags;
  logic           m_ovr;
  longint         m_y   [NCH];
  int             m_run [NCH];
  longint         m_hist[NCH][HS];
  bit             m_val [NCH][HS];
  int             m_addr;

  task automatic model_reset();
    m_thr = 0; m_cnt = 1; m_en = '1; m_flags = 0; m_ovr = 0; m_addr = 0;
    for (int c = 0; c < NCH; c++) begin
      m_y[c] = 0; m_run[c] = 0;
      for (int a = 0; a < HS; a++) m_val[c][a] = 0;
    end
  endtask

  task automatic model_turn(input longint u0, input longint u1);
    longint u[NCH];
    u[0] = u0; u[1] = u1;
    for (int c = 0; c < NCH; c++) begin
      longint lim, d;
      int need;
      m_y[c] = m_y[c] + ((u[c] - m_y[c]) >>> AL_A);
      lim  = m_val[c][m_addr] ? m_hist[c][m_addr] : 0;
      need = (m_cnt == 0) ? 1 : int'(m_cnt);
      if (m_en[c] && m_y[c] < lim) begin
        if (m_run[c] + 1 >= need) m_flags[c] = 1'b1;
        m_run[c] = (m_run[c] < (1 << CWD) - 1) ? m_run[c] + 1 : m_run[c];
      end else begin
        m_run[c] = 0;
      end
      d = m_y[c] - m_y[c] / (1 << SH) - longint'(m_thr);
      m_hist[c][m_addr] = (d < 0) ? 0 : d;
      m_val[c][m_addr]  = 1;
    end
    m_addr = (m_addr + 1) % HS;
  endtask

  // Compare process: whenever DUT A has been idle and undisturbed for a few cycles
  bit act = 1;
  int settle = 0;
  always @(negedge clk) begin
    if (act || busy_a || rst_a) settle <= 0;
    else begin
      settle <= settle + 1;
      if (settle >= 2) begin
        chk("model_threshold", thr_a, m_thr);
        chk("model_tripcount", cnt_a, m_cnt);
        chk("model_enable", en_a, m_en);
        chk("model_flags", flags_a, m_flags);
        chk("model_trigger", trig_a, |m_flags);
        chk("model_overrun", ovr_a, m_ovr);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_idle(input int min_cycles, output int lat);
    lat = 0;
    do begin tick(); lat++; end while ((busy_a || lat < min_cycles) && lat < 100);
    if (busy_a) chk("busy_timeout", busy_a, 0);
  endtask

  task automatic reset_a();
    act = 1; rst_a = 1; tick(); rst_a = 0; model_reset(); act = 0;
  endtask

  // kind: 0 threshold, 1 tripCount, 2 enable, 3 clear
  task automatic cfg(input int kind, input logic [DW-1:0] data);
    act = 1;
    bus_a.gpioData = data;
    case (kind)
      0: begin bus_a.thresholdStrobe = 1; m_thr = data; end
      1: begin bus_a.countStrobe = 1; m_cnt = data[CWD-1:0]; end
      2: begin bus_a.enableStrobe = 1; m_en = data[NCH-1:0]; end
      default: begin bus_a.clearStrobe = 1; m_flags = 0; m_ovr = 0; end
    endcase
    tick();
    bus_a.thresholdStrobe = 0; bus_a.countStrobe = 0;
    bus_a.enableStrobe = 0; bus_a.clearStrobe = 0;
    act = 0;
  endtask

  task automatic turn(input logic [DW-1:0] u0, input logic [DW-1:0] u1, output int lat);
    act = 1;
    bus_a.buttonSum = {u1, u0};
    bus_a.turnByTurnToggle = ~bus_a.turnByTurnToggle;
    model_turn(u0, u1);
    wait_idle(0, lat);
    act = 0;
  endtask

  task automatic turn_b(input logic [DW-1:0] u);
    int n;
    bus_b.buttonSum = {u, u};
    bus_b.turnByTurnToggle = ~bus_b.turnByTurnToggle;
    n = 0;
    do begin tick(); n++; end while (busy_b && n < 100);
    if (busy_b) chk("busy_b_timeout", busy_b, 0);
  endtask

  int lat;
  longint yb;

  initial begin
    bus_a.gpioData = 0; bus_a.thresholdStrobe = 0; bus_a.countStrobe = 0;
    bus_a.enableStrobe = 0; bus_a.clearStrobe = 0; bus_a.turnByTurnToggle = 0;
    bus_a.buttonSum = 0;
    bus_b.gpioData = 0; bus_b.thresholdStrobe = 0; bus_b.countStrobe = 0;
    bus_b.enableStrobe = 0; bus_b.clearStrobe = 0; bus_b.turnByTurnToggle = 0;
    bus_b.buttonSum = 0;
    rst_a = 1; rst_b = 1;
    idle(2);
    rst_b = 0;
    reset_a();

    chk("rst_threshold", thr_a, 0);
    chk("rst_tripcount", cnt_a, 1);
    chk("rst_enable", en_a, 2'b11);
    chk("rst_flags", flags_a, 0);
    chk("rst_trigger", trig_a, 0);
    chk("rst_overrun", ovr_a, 0);
    chk("rst_busy", busy_a, 0);

    // Invalid history reads as limit 0, then the 6000 limit boundary
    cfg(0, 1000); cfg(1, 1);
    repeat (4) turn(0, 0, lat);
    chk("zero_sum_no_trip", flags_a, 0);
    repeat (4) turn(8000, 8000, lat);
    turn(8000, 6000, lat); idle(3);
    chk("at_limit_no_trip", flags_a, 0);
    turn(8000, 5999, lat);
    chk("turn_latency", lat, 3 * NCH + 1);
    idle(3);
    chk("below_limit_flags", flags_a, 2'b10);
    chk("below_limit_trigger", trig_a, 1);
    cfg(3, 0); idle(3);
    chk("clear_flags", flags_a, 0);
    chk("clear_trigger", trig_a, 0);

    // Threshold above the stored fraction clamps the limit to zero
    cfg(0, 9000);
    repeat (4) turn(8000, 8000, lat);
    turn(100, 100, lat); idle(3);
    chk("clamped_limit_no_trip", flags_a, 0);

    // Consecutive-turn requirement of 3
    reset_a(); cfg(0, 1000); cfg(1, 3);
    repeat (4) turn(8000, 8000, lat);
    repeat (2) turn(5000, 8000, lat);
    repeat (4) turn(8000, 8000, lat);
    repeat (2) turn(5000, 8000, lat);
    idle(3);
    chk("count3_two_turns", flags_a, 0);
    turn(5000, 8000, lat); idle(3);
    chk("count3_third_turn", flags_a, 2'b01);

    // Overrun: second toggle two cycles into a turn
    reset_a(); cfg(0, 1000);
    repeat (4) turn(8000, 8000, lat);
    act = 1;
    bus_a.buttonSum = {32'd8000, 32'd8000};
    bus_a.turnByTurnToggle = ~bus_a.turnByTurnToggle;
    model_turn(8000, 8000);
    idle(2);
    bus_a.buttonSum = {32'd8000, 32'd5000};
    bus_a.turnByTurnToggle = ~bus_a.turnByTurnToggle;
    model_turn(5000, 8000);
    m_ovr = 1;
    wait_idle(10, lat);
    act = 0; idle(3);
    chk("overrun_set", ovr_a, 1);
    chk("overrun_second_turn", flags_a, 2'b01);
    cfg(3, 0); idle(3);
    chk("overrun_cleared", ovr_a, 0);

    // Disabled channel never trips
    cfg(2, 1);
    turn(8000, 5000, lat); idle(3);
    chk("disabled_no_trip", flags_a, 0);

    // Reset during SMOOTH aborts the turn and invalidates history
    act = 1;
    bus_a.buttonSum = {32'd100, 32'd100};
    bus_a.turnByTurnToggle = ~bus_a.turnByTurnToggle;
    tick();
    reset_a();
    chk("midrst_threshold", thr_a, 0);
    chk("midrst_tripcount", cnt_a, 1);
    chk("midrst_enable", en_a, 2'b11);
    chk("midrst_flags", flags_a, 0);
    chk("midrst_overrun", ovr_a, 0);
    chk("midrst_busy", busy_a, 0);
    idle(3);
    chk("midrst_no_spurious_turn", busy_a, 0);
    cfg(0, 1000);
    turn(100, 100, lat); idle(3);
    chk("midrst_history_invalid", flags_a, 0);

    // Clear on the same cycle as a channel-0 trip
    reset_a(); cfg(0, 1000);
    repeat (4) turn(8000, 8000, lat);
    turn(8000, 5000, lat); idle(3);
    chk("pre_clear_flags", flags_a, 2'b10);
    act = 1;
    bus_a.buttonSum = {32'd8000, 32'd5000};
    bus_a.turnByTurnToggle = ~bus_a.turnByTurnToggle;
    m_flags = 0; m_ovr = 0;
    model_turn(5000, 8000);
    idle(2);
    bus_a.clearStrobe = 1;
    tick();
    bus_a.clearStrobe = 0;
    wait_idle(0, lat);
    act = 0; idle(3);
    chk("clear_vs_trip", flags_a, 2'b01);

    // Smoothing with L2_ALPHA=3 on a 0 -> 8000 step
    yb = 0;
    turn_b(8000);
    yb = yb + ((8000 - yb) >>> AL_B);
    chk("smooth_turn1", dut_b.y_reg[0], 1000);
    chk("smooth_turn1_model", dut_b.y_reg[0], yb);
    turn_b(8000);
    yb = yb + ((8000 - yb) >>> AL_B);
    chk("smooth_turn2", dut_b.y_reg[0], 1875);
    chk("smooth_turn2_model", dut_b.y_reg[1], yb);

    idle(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/loss_of_beam_multi.md
Name: loss_of_beam_multi

Overview:
- Multi-channel, parametrised successor to the single-channel loss-of-beam trigger.
- On every turn-by-turn event it smooths each channel's button sum and compares it against a limit derived from that channel's own sum HISTORY_SIZE turns earlier.
- A channel trips after a programmable number of consecutive below-limit turns; the trigger latches until cleared.
- Sits between the turn-by-turn button-sum block and the acquisition/trigger fabric; configured over GPIO strobes.

Parameters:
NCHAN, 4, number of independent channels (1..16)
DATA_WIDTH, 32, unsigned sample width
HISTORY_SIZE, 64, turns of limit history per channel (power of 2, >=2)
DATA_SHIFT, 3, limit fraction: limit = s - (s>>DATA_SHIFT) - threshold
L2_ALPHA, 3, smoothing shift (0 = no smoothing)
COUNT_WIDTH, 4, width of consecutive-trip counter/setting

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
gpioData  in  DATA_WIDTH  configuration write data
thresholdStrobe  in  1  load threshold <= gpioData
countStrobe  in  1  load tripCount <= gpioData[COUNT_WIDTH-1:0]
enableStrobe  in  1  load channelEnable <= gpioData[NCHAN-1:0]
clearStrobe  in  1  clear latched trigger, tripFlags, overrun
turnByTurnToggle  in  1  toggles once per new turn sample set
buttonSum  in  NCHAN*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
threshold  out  DATA_WIDTH  threshold readback
tripCount  out  COUNT_WIDTH  consecutive-turn requirement readback
channelEnable  out  NCHAN  enable readback
tripFlags  out  NCHAN  sticky per-channel trip flags
lossOfBeamTrigger  out  1  OR of tripFlags, registered
overrun  out  1  sticky: toggle seen while busy
busy  out  1  high while sequencer processes a turn

Behaviour:
- Reset (sync, one cycle): threshold=0, tripCount=1, channelEnable=all 1, tripFlags=0, lossOfBeamTrigger=0, overrun=0, busy=0, history address=0, smoothed values=0, run counters=0, turnByTurnMatch<=turnByTurnToggle. History RAM is not cleared; a valid bit per address (cleared by reset) forces a read limit of 0 until the location has been written. Reset mid-turn aborts the sequence with no partial writes.
- Config strobes take effect the next cycle and may arrive during busy. The new value applies from the next pipeline stage that reads it.
- States: IDLE, SMOOTH, LIMIT, WRITE; the channel index c iterates 0..NCHAN-1.
- IDLE: when turnByTurnToggle != turnByTurnMatch, flip turnByTurnMatch, snapshot all of buttonSum, set busy, set c=0, go to SMOOTH.
- SMOOTH: y[c] <= y[c] + ((u[c] - y[c]) >>> L2_ALPHA), computed signed in DATA_WIDTH+1 bits. Issue the history read at {c, addr}.
- LIMIT: compare the new y[c] against the history limit (0 if invalid).
  - below = (y < limit) && channelEnable[c].
  - If below, run[c] <= run[c]+1, saturating. Otherwise run[c] <= 0.
  - If below and run[c]+1 >= tripCount, set tripFlags[c]. tripCount=0 is treated as 1.
  - Compute d = y - (y>>DATA_SHIFT) - threshold. If the result is negative (borrow), d=0.
- WRITE: history[{c,addr}] <= d, mark valid. If c==NCHAN-1, addr <= addr+1 (wraps mod HISTORY_SIZE), clear busy, go to IDLE; otherwise c+1 and go to SMOOTH.
- Latency: 3*NCHAN+1 cycles from toggle to busy low. lossOfBeamTrigger goes high 1 cycle after the tripFlags set.
- A toggle change while busy sets overrun. The event is serviced on return to IDLE (match comparison); double toggles are lost.
- clearStrobe coincident with a new trip: the set wins (flag remains 1). Clear does not reset run counters or history.
- Disabled channel: still smoothed and written to history, but never counts or trips.

Test Plan:
- NCHAN=2, HISTORY_SIZE=4, L2_ALPHA=0, DATA_SHIFT=3, threshold=1000, tripCount=1; 4 turns at sum 8000 on both channels, then ch1=5999 -> tripFlags=2'b10, lossOfBeamTrigger=1; ch1=6000 instead -> no trip.
- Same setup, first 4 turns after reset with sum 0 -> no trip (invalid history limit=0); threshold=9000 with s=8000 -> stored limit clamps to 0, never trips.
- tripCount=3: ch0 below limit for 2 turns, recovers, then below for 3 -> trip only on the 3rd consecutive turn.
- Toggle again 2 cycles after a turn starts -> overrun=1 and the second turn is processed after busy falls; clearStrobe -> overrun=0.
- channelEnable=2'b01 with ch1 dropping -> no trip; assert reset mid-SMOOTH -> all outputs at reset values, history unchanged.
- clearStrobe on the same cycle ch0 trips -> tripFlags[0] stays 1; L2_ALPHA=3 with step 0->8000 -> y=1000 after 1 turn, 1875 after 2.
